execute_cc_stage: RTL and testbench

EXECUTE_CC_STAGE -- requirements
Module: execute_cc_stage

---
 rtl/y86_pkg.sv | 28 ++
 rtl/cond_eval.sv | 27 ++
 rtl/execute_cc_stage.sv | 105 ++++++++++
 tb/tb_execute_cc_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the execute stage: icodes, condition ifuns and status codes.
package y86_pkg;

  localparam logic [3:0] IcodeHalt   = 4'd0;
  localparam logic [3:0] IcodeCmovxx = 4'd2;
  localparam logic [3:0] IcodeOpq    = 4'd6;
  localparam logic [3:0] IcodeJxx    = 4'd7;

  // ifun values selecting a branch / conditional-move condition
  typedef enum logic [3:0] {
    CondAlways = 4'd0,
    CondLe     = 4'd1,
    CondL      = 4'd2,
    CondE      = 4'd3,
    CondNe     = 4'd4,
    CondGe     = 4'd5,
    CondG      = 4'd6
  } cond_e;

  // Status AOK/HLT/ADR/INS packed into two bits
  typedef enum logic [1:0] {
    StatAok = 2'd0,
    StatHlt = 2'd1,
    StatAdr = 2'd2,
    StatIns = 2'd3
  } stat_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a Y86 condition (ifun) against the condition codes.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       cnd
);

  // Decode ifun; undefined conditions (7..15) never fire
  always_comb begin
    cnd = 1'b0;
    unique case (ifun)
      CondAlways: cnd = 1'b1;
      CondLe:     cnd = (sf ^ of) | zf;
      CondL:      cnd = sf ^ of;
      CondE:      cnd = zf;
      CondNe:     cnd = ~zf;
      CondGe:     cnd = ~(sf ^ of);
      CondG:      cnd = ~(sf ^ of) & ~zf;
      default:    cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_cc_stage.sv
// Execute-stage condition-code register and registered result with valid/ready handshake.
module execute_cc_stage
  import y86_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_icode,
  input  logic [3:0]       in_ifun,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic [1:0]       in_stat,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_valE,
  output logic [3:0]       out_icode,
  output logic             out_cnd,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_vale_q, out_vale_d;
  logic [3:0]       out_icode_q, out_icode_d;
  logic             out_cnd_q, out_cnd_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;
  logic             xfer;
  logic             cnd;

  // Condition is judged on the CC already registered, never this cycle's update
  cond_eval u_cond_eval (
    .ifun (in_ifun),
    .zf   (zf_q),
    .sf   (sf_q),
    .of   (of_q),
    .cnd  (cnd)
  );

  // Handshake, output register and CC next-state
  always_comb begin
    in_ready    = ~out_valid_q | out_ready;
    xfer        = in_valid & in_ready & ~flush;
    out_valid_d = out_valid_q;
    out_vale_d  = out_vale_q;
    out_icode_d = out_icode_q;
    out_cnd_d   = out_cnd_q;
    zf_d        = zf_q;
    sf_d        = sf_q;
    of_d        = of_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (xfer) begin
      out_vale_d  = alu_result;
      out_icode_d = in_icode;
      out_cnd_d   = ((in_icode == IcodeJxx) || (in_icode == IcodeCmovxx)) ? cnd : 1'b0;
      if ((in_icode == IcodeOpq) && (in_stat == StatAok)) begin
        zf_d = (alu_result == '0);
        sf_d = alu_result[WIDTH-1];
        of_d = alu_overflow;
      end
    end
  end

  // State registers; reset leaves ZF set as if the last result were zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_vale_q  <= '0;
      out_icode_q <= IcodeHalt;
      out_cnd_q   <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_vale_q  <= out_vale_d;
      out_icode_q <= out_icode_d;
      out_cnd_q   <= out_cnd_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_valE  = out_vale_q;
  assign out_icode = out_icode_q;
  assign out_cnd   = out_cnd_q;
  assign cc_zf     = zf_q;
  assign cc_sf     = sf_q;
  assign cc_of     = of_q;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Directed bench for execute_cc_stage: reference model compared every cycle plus literal checks.
module tb_execute_cc_stage;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_icode = 4'd0;
  logic [3:0]   in_ifun = 4'd0;
  logic [W-1:0] alu_result = '0;
  logic         alu_overflow = 1'b0;
  logic [1:0]   in_stat = 2'd0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b1;
  logic         out_valid;
  logic [W-1:0] out_valE;
  logic [3:0]   out_icode;
  logic         out_cnd;
  logic         cc_zf, cc_sf, cc_of;

  int total = 0;
  int bad = 0;

  execute_cc_stage #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_icode     (in_icode),
    .in_ifun      (in_ifun),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .in_stat      (in_stat),
    .flush        (flush),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_valE     (out_valE),
    .out_icode    (out_icode),
    .out_cnd      (out_cnd),
    .cc_zf        (cc_zf),
    .cc_sf        (cc_sf),
    .cc_of        (cc_of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: condition from the table, in terms of "less than" and "equal"
  function automatic logic model_cond(input logic [3:0] f, input logic z, input logic s,
                                      input logic o);
    logic lt;
    lt = s ^ o;
    case (f)
      4'd0: return 1'b1;
      4'd1: return lt || z;
      4'd2: return lt;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !lt;
      4'd6: return !lt && !z;
      default: return 1'b0;
    endcase
  endfunction

  logic         m_valid, m_cnd, m_zf, m_sf, m_of;
  logic [W-1:0] m_vale;
  logic [3:0]   m_icode;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_vale <= '0; m_icode <= 4'd0; m_cnd <= 1'b0;
      m_zf <= 1'b1; m_sf <= 1'b0; m_of <= 1'b0;
    end else begin
      if (flush) begin
        m_valid <= 1'b0;
      end else if (in_valid && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_vale  <= alu_result;
        m_icode <= in_icode;
        m_cnd   <= (in_icode == 4'd7 || in_icode == 4'd2) ?
                   model_cond(in_ifun, m_zf, m_sf, m_of) : 1'b0;
        if (in_icode == 4'd6 && in_stat == 2'd0) begin
          m_zf <= (alu_result == 0);
          m_sf <= alu_result[W-1];
          m_of <= alu_overflow;
        end
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
    chk("cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, m_zf, m_sf, m_of});
    if (m_valid) begin
      chk("out_valE", out_valE, m_vale);
      chk("out_icode", {60'd0, out_icode}, {60'd0, m_icode});
      chk("out_cnd", {63'd0, out_cnd}, {63'd0, m_cnd});
    end
  end

  task automatic step(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [W-1:0] res, input logic ovf, input logic [1:0] st,
                      input logic fl, input logic ordy);
    in_valid = v; in_icode = ic; in_ifun = fn; alu_result = res;
    alu_overflow = ovf; in_stat = st; flush = fl; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    chk("rst_icode", {60'd0, out_icode}, 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // OPq 0xC350+0xC350
    step(1, 4'd6, 4'd0, 64'h186A0, 0, 2'd0, 0, 1);
    chk("add_vale", out_valE, 64'h186A0);
    chk("add_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b000);
    // OPq producing the min negative with overflow
    step(1, 4'd6, 4'd0, 64'h8000000000000000, 1, 2'd0, 0, 1);
    chk("neg_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);
    chk("neg_vale", out_valE, 64'h8000000000000000);
    step(1, 4'd7, 4'd2, 64'h10, 0, 2'd0, 0, 1);  // jl
    chk("jl_cnd", {63'd0, out_cnd}, 64'd0);
    step(1, 4'd7, 4'd1, 64'h20, 0, 2'd0, 0, 1);  // jle
    chk("jle_cnd", {63'd0, out_cnd}, 64'd0);
    // OPq zero then cmove / jne / jmp
    step(1, 4'd6, 4'd1, 64'h0, 0, 2'd0, 0, 1);
    chk("zero_zf", {63'd0, cc_zf}, 64'd1);
    step(1, 4'd2, 4'd3, 64'h30, 0, 2'd0, 0, 1);
    chk("cmove_cnd", {63'd0, out_cnd}, 64'd1);
    step(1, 4'd7, 4'd0, 64'h40, 0, 2'd0, 0, 1);
    chk("jmp_cnd", {63'd0, out_cnd}, 64'd1);
    step(1, 4'd7, 4'd4, 64'h77, 0, 2'd0, 0, 1);
    chk("jne_cnd", {63'd0, out_cnd}, 64'd0);
    // Non-branch icode never reports a condition
    step(1, 4'd3, 4'd0, 64'h55, 0, 2'd0, 0, 1);
    chk("irmov_cnd", {63'd0, out_cnd}, 64'd0);

    // Downstream stall for 3 cycles with a CC-changing OPq held at the input
    for (int i = 0; i < 3; i++) begin
      step(1, 4'd6, 4'd0, 64'h5, 0, 2'd0, 0, 0);
      chk("stall_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_vale", out_valE, 64'h55);
      chk("stall_zf", {63'd0, cc_zf}, 64'd1);
    end
    step(1, 4'd6, 4'd0, 64'h5, 0, 2'd0, 0, 1);
    chk("release_vale", out_valE, 64'h5);
    chk("release_zf", {63'd0, cc_zf}, 64'd0);

    // Flush beats a valid OPq
    step(1, 4'd6, 4'd0, 64'h0, 0, 2'd0, 1, 1);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_zf", {63'd0, cc_zf}, 64'd0);
    // OPq with ADR status passes through but leaves CC alone
    step(1, 4'd6, 4'd0, 64'h0, 0, 2'd2, 0, 1);
    chk("adr_valid", {63'd0, out_valid}, 64'd1);
    chk("adr_zf", {63'd0, cc_zf}, 64'd0);
    step(0, 4'd0, 4'd0, 64'h0, 0, 2'd0, 0, 1);
    chk("drain_valid", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset mid-stream
    step(1, 4'd6, 4'd0, 64'h8000000000000001, 0, 2'd0, 0, 1);
    chk("pre_rst_sf", {63'd0, cc_sf}, 64'd1);
    in_icode = 4'd7; in_ifun = 4'd6;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_vale", out_valE, 64'd0);
    chk("arst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
    step(1, 4'd7, 4'd6, 64'h1, 0, 2'd0, 0, 1);  // jg on reset CC
    chk("jg_cnd", {63'd0, out_cnd}, 64'd0);
    step(1, 4'd7, 4'd5, 64'h2, 0, 2'd0, 0, 1);  // jge on reset CC
    chk("jge_cnd", {63'd0, out_cnd}, 64'd1);
    step(0, 4'd0, 4'd0, 64'h0, 0, 2'd0, 0, 1);
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
